// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scan controller.
//   SEG_NUM_DIGITS  number of multiplexed digits
//   SEG_BLANK       all cathodes off (active-low)
//   SEG_HEX         active-low {g,f,e,d,c,b,a} encodings for hex 0-F
//   digit_idx_t     2-bit digit index
//   digit_state_e   scan states DIG0..DIG3
package seg_pkg;

  localparam int unsigned SEG_NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_state_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: groups the display controller's source/control inputs
// and the active-low display pins.
//   value_a/value_b  16-bit result sources (nibble 0 = rightmost digit)
//   sel_b, load      source select and level-sensitive latch strobe
//   blank_lz, blink  leading-zero blanking and blink request
//   seg/an/dp        active-low cathodes, anodes, decimal point
//   master: drives sources/controls; slave: the scan controller
interface seg_scan_ctrl_if;
  logic [15:0] value_a;
  logic [15:0] value_b;
  logic        sel_b;
  logic        load;
  logic        blank_lz;
  logic        blink;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  modport master (
    output value_a, value_b, sel_b, load, blank_lz, blink,
    input  seg, an, dp
  );

  modport slave (
    input  value_a, value_b, sel_b, load, blank_lz, blink,
    output seg, an, dp
  );
endinterface

// File: rtl/seg_scan_ctrl_hex_decoder.sv
// seg_hex_decoder: combinational hex nibble to active-low seven-segment code.
//   i_nibble  4-bit hex value
//   o_seg     {g,f,e,d,c,b,a}, active-low
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_HEX[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexes a 4-digit active-low seven-segment display
// between digits and between two 16-bit sources latched on a load strobe.
//   clk     system clock
//   resetn  synchronous active-low reset
//   bus     seg_scan_ctrl_if.slave: value_a, value_b, sel_b, load, blank_lz,
//           blink in; seg, an, dp out (registered, update on scan tick)
// Optional: define SEG_BLINK_EN to enable anode blinking driven by blink.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = $clog2(REFRESH_DIV),
  parameter int unsigned BLINK_DIV   = 50000000
) (
  input  logic               clk,
  input  logic               resetn,
  seg_scan_ctrl_if.slave     bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;
  logic [15:0]      r_shadow;
  logic             r_src_b;
  digit_state_e     r_state;
  digit_state_e     w_state_nxt;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg_dec;
  logic             w_lz_zero;
  logic [3:0]       w_an_digit;
  logic [6:0]       w_seg_nxt;
  logic [3:0]       w_an_nxt;
  logic             w_dp_nxt;
  logic             w_force_dark;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;
  logic             r_dp;

  // Refresh prescaler
  assign w_tick = (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!resetn)     r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  // Shadow register; a load coinciding with a tick is only seen next slot
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_shadow <= '0;
      r_src_b  <= 1'b0;
    end else if (bus.load) begin
      r_shadow <= bus.sel_b ? bus.value_b : bus.value_a;
      r_src_b  <= bus.sel_b;
    end
  end

  // Scan FSM: state register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= DIG0;
    else         r_state <= w_state_nxt;
  end

  // Scan FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      unique case (r_state)
        DIG0: w_state_nxt = DIG1;
        DIG1: w_state_nxt = DIG2;
        DIG2: w_state_nxt = DIG3;
        DIG3: w_state_nxt = DIG0;
      endcase
    end
  end

  // Scan FSM: outputs for the digit being entered on the tick
  always_comb begin
    w_nibble   = r_shadow[3:0];
    w_lz_zero  = 1'b0;
    w_an_digit = 4'b1110;
    unique case (w_state_nxt)
      DIG0: begin
        w_nibble   = r_shadow[3:0];
        w_lz_zero  = 1'b0;
        w_an_digit = 4'b1110;
      end
      DIG1: begin
        w_nibble   = r_shadow[7:4];
        w_lz_zero  = (r_shadow[15:4] == '0);
        w_an_digit = 4'b1101;
      end
      DIG2: begin
        w_nibble   = r_shadow[11:8];
        w_lz_zero  = (r_shadow[15:8] == '0);
        w_an_digit = 4'b1011;
      end
      DIG3: begin
        w_nibble   = r_shadow[15:12];
        w_lz_zero  = (r_shadow[15:12] == '0);
        w_an_digit = 4'b0111;
      end
    endcase
  end

  seg_hex_decoder u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_dec)
  );

  always_comb begin
    w_seg_nxt = w_seg_dec;
    w_an_nxt  = w_an_digit;
    if (bus.blank_lz && w_lz_zero) begin
      w_seg_nxt = SEG_BLANK;
      w_an_nxt  = '1;
    end
    w_dp_nxt = !((w_state_nxt == DIG0) && r_src_b);
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] r_bcnt;
  logic             r_bphase;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_bcnt   <= '0;
      r_bphase <= 1'b0;
    end else if (r_bcnt == BLK_MAX) begin
      r_bcnt   <= '0;
      r_bphase <= ~r_bphase;
    end else begin
      r_bcnt   <= r_bcnt + 1'b1;
    end
  end

  assign w_force_dark = bus.blink & r_bphase;
`else
  assign w_force_dark = 1'b0;
`endif

  // Display registers load only on the tick
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
      r_dp  <= 1'b1;
    end else if (w_tick) begin
      r_seg <= w_seg_nxt;
      r_an  <= w_force_dark ? 4'b1111 : w_an_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed, table-driven bench for seg_scan_ctrl with
// REFRESH_DIV=4 (one scan slot = 4 clocks).
module tb_seg_scan_ctrl;

  localparam logic [6:0] H0 = 7'b1000000;
  localparam logic [6:0] H1 = 7'b1111001;
  localparam logic [6:0] H2 = 7'b0100100;
  localparam logic [6:0] H3 = 7'b0110000;
  localparam logic [6:0] H4 = 7'b0011001;
  localparam logic [6:0] H5 = 7'b0010010;
  localparam logic [6:0] HB = 7'b0000011;
  localparam logic [6:0] HE = 7'b0000110;
  localparam logic [6:0] HF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;
  // Anode codes packed {DIG3,DIG2,DIG1,DIG0}
  localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  typedef struct {
    logic [15:0]      a;
    logic [15:0]      b;
    logic             sel;
    logic             blz;
    logic [3:0][6:0]  seg;  // expected per digit {d3,d2,d1,d0}
    logic [3:0][3:0]  an;
    logic [3:0]       dp;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [1:0] tb_idx;

  always #5 clk = ~clk;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_disp(input string nm, input logic [6:0] s, input logic [3:0] a, input logic d);
    chk({nm, "_seg"}, {9'd0, bus.seg}, {9'd0, s});
    chk({nm, "_an"},  {12'd0, bus.an}, {12'd0, a});
    chk({nm, "_dp"},  {15'd0, bus.dp}, {15'd0, d});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic slot();
    repeat (4) cyc();
    tb_idx = tb_idx + 2'd1;
  endtask

  vec_t vec [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec[0] = '{a:16'h1234, b:16'h0000, sel:1'b0, blz:1'b0,
               seg:{H1, H2, H3, H4}, an:AN_ALL, dp:4'b1111};
    vec[1] = '{a:16'h0050, b:16'h0000, sel:1'b0, blz:1'b1,
               seg:{BL, BL, H5, H0}, an:{4'b1111, 4'b1111, 4'b1101, 4'b1110}, dp:4'b1111};
    vec[2] = '{a:16'h0000, b:16'h0000, sel:1'b0, blz:1'b1,
               seg:{BL, BL, BL, H0}, an:{4'b1111, 4'b1111, 4'b1111, 4'b1110}, dp:4'b1111};
    vec[3] = '{a:16'h1234, b:16'hBEEF, sel:1'b1, blz:1'b0,
               seg:{HB, HE, HE, HF}, an:AN_ALL, dp:4'b1110};
    vec[4] = '{a:16'hBEEF, b:16'h1234, sel:1'b0, blz:1'b0,
               seg:{HB, HE, HE, HF}, an:AN_ALL, dp:4'b1111};
    vec[5] = '{a:16'h0000, b:16'hFFFF, sel:1'b0, blz:1'b0,
               seg:{H0, H0, H0, H0}, an:AN_ALL, dp:4'b1111};

    bus.value_a  = '0;
    bus.value_b  = '0;
    bus.sel_b    = 1'b0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.blink    = 1'b0;

    // Reset and startup latency
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_disp($sformatf("rst_hold%0d", i), BL, 4'b1111, 1'b1);
    end
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_disp($sformatf("rst_post%0d", i), BL, 4'b1111, 1'b1);
    end
    cyc();
    tb_idx = 2'd1;
    chk_disp("first_tick", H0, 4'b1101, 1'b1);

    // Table-driven vectors: load in first cycle of a slot, then 4 ticks
    for (int v = 0; v < 6; v++) begin
      bus.value_a  = vec[v].a;
      bus.value_b  = vec[v].b;
      bus.sel_b    = vec[v].sel;
      bus.blank_lz = vec[v].blz;
      bus.load     = 1'b1;
      cyc();
      bus.load     = 1'b0;
      repeat (3) cyc();
      tb_idx = tb_idx + 2'd1;
      chk_disp($sformatf("v%0d_d%0d", v, tb_idx),
               vec[v].seg[tb_idx], vec[v].an[tb_idx], vec[v].dp[tb_idx]);
      for (int s = 0; s < 3; s++) begin
        slot();
        chk_disp($sformatf("v%0d_d%0d", v, tb_idx),
                 vec[v].seg[tb_idx], vec[v].an[tb_idx], vec[v].dp[tb_idx]);
      end
    end

    // Load/tick collision
    bus.sel_b = 1'b0;
    bus.blank_lz = 1'b0;
    bus.value_a = 16'h1111;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    repeat (2) cyc();
    bus.value_a = 16'h2222;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    tb_idx = tb_idx + 2'd1;
    chk_disp("coll_old", H1, AN_ALL[tb_idx], 1'b1);
    slot();
    chk_disp("coll_new", H2, AN_ALL[tb_idx], 1'b1);

    // Load held high re-latches every cycle
    bus.load = 1'b1;
    bus.value_a = 16'h1111; cyc();
    bus.value_a = 16'h2222; cyc();
    bus.value_a = 16'h3333; cyc();
    bus.value_a = 16'h4444; cyc();
    bus.load = 1'b0;
    tb_idx = tb_idx + 2'd1;
    chk_disp("held_tick", H3, AN_ALL[tb_idx], 1'b1);
    slot();
    chk_disp("held_next", H4, AN_ALL[tb_idx], 1'b1);

    // Mid-scan reset while DIG2 lit
    for (int i = 0; i < 4 && tb_idx != 2'd2; i++) slot();
    chk("mid_at_dig2", {14'd0, tb_idx}, 16'd2);
    chk_disp("mid_dig2", H4, 4'b1011, 1'b1);
    cyc();
    resetn = 1'b0;
    cyc();
    chk_disp("mid_rst", BL, 4'b1111, 1'b1);
    resetn = 1'b1;
    repeat (3) cyc();
    chk_disp("mid_post3", BL, 4'b1111, 1'b1);
    cyc();
    chk_disp("mid_first_tick", H0, 4'b1101, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexes the board's shared 4-digit seven-segment display (seg/an/dp, all active-low) between digits and between two 16-bit result sources from the pipelined MIPS top.
- Latches the selected source on a load strobe, for example on CPU `done`, or every cycle for a live view.
- Scans the digits with a programmable refresh prescaler and optionally blanks leading zeros.
- Sits between the CPU datapath result/status registers and the top-level display pins.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit is driven per scan slot; minimum 2.
- CNT_W, $clog2(REFRESH_DIV): prescaler width; derived, do not override.
- BLINK_DIV, 50000000: blink half-period in clk cycles; used only with SEG_BLINK_EN.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- value_a  in  16  source A, the CPU result register; 4 hex nibbles, nibble 0 = rightmost digit.
- value_b  in  16  source B, the cycle counter.
- sel_b  in  1  1 = latch value_b on load, 0 = latch value_a.
- load  in  1  latch strobe; level-sensitive, sampled every clk.
- blank_lz  in  1  1 = blank leading-zero digits.
- blink  in  1  blink request; ignored unless SEG_BLINK_EN.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- an  out  4  anodes, one-hot active-low, an[0] = rightmost.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset: clk and resetn form one clock domain; reset is synchronous and active-low, applied on the clk edge while resetn=0.
- Reset values: an=4'b1111, seg=7'b1111111, dp=1, prescaler=0, digit index=0, shadow value=16'h0000, shadow source flag=0, blink counter/phase=0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0. tick=1 in the cycle the count equals REFRESH_DIV-1.
- Digit index (2-bit) advances on tick, wrapping 3->0. States are DIG0->DIG1->DIG2->DIG3->DIG0, with no other states.
- Output update: seg/an/dp are registered and update only on the tick edge. They drive the digit the index moves into: nibble shadow[4*idx+3 -> 4*idx], decoded to hex 0-F.
- Startup: the first tick after reset lights DIG1. DIG0 is first lit after 4 ticks; outputs are dark until the first tick.
- load: shadow <= sel_b ? value_b : value_a on the same edge, and shadow source flag <= sel_b.
  - load and tick in the same cycle: the tick decodes the old shadow; the new value is visible from the next tick.
  - load held high: shadow re-latches every cycle.
- Leading-zero blanking (blank_lz=1): digit k is blanked when shadow nibbles k..3 are all zero and k>0.
  - A blanked digit drives an=4'b1111 and seg=7'b1111111 for its slot.
  - DIG0 is never blanked, so 16'h0000 shows "0".
  - blank_lz is sampled at tick.
- dp: low only while DIG0 is driven and the shadow source flag=1, marking source B. Otherwise dp=1.
- resetn low mid-scan: all state returns to reset values on that edge, and the scan restarts from DIG0 index.

Optional Feature:
- Macro: SEG_BLINK_EN.
- Defined:
  - A blink counter counts 0..BLINK_DIV-1 and toggles blink_phase at wrap.
  - While blink=1 and blink_phase=1, an is forced to 4'b1111 at output register load; the scan continues underneath.
  - blink=0 clears the forcing at the next tick.
- Undefined: no blink counter is instantiated; blink is unconnected and ignored; behaviour is as above.

Decomposition:
- Package seg_pkg:
  - SEG_NUM_DIGITS=4.
  - SEG_BLANK=7'b1111111.
  - SEG_HEX[16] active-low encodings, e.g. 0=7'b1000000, 1=7'b1111001, 4=7'b0011001, 5=7'b0010010, E=7'b0000110.
  - typedef digit_idx_t (2-bit).
- Sub-module seg_hex_decoder: combinational nibble -> seg lookup from seg_pkg. It is instantiated once and fed by the nibble mux.

Test Plan:
All cases run with REFRESH_DIV=4.
1. Reset: resetn=0 for 3 clks, then run 3 clks -> an=4'b1111, seg=7'b1111111, dp=1 throughout. The first tick lands at clk 4 after release.
2. Basic scan: value_a=16'h1234, sel_b=0, one-cycle load, blank_lz=0 -> over 16 clks an steps 1101,1011,0111,1110 with seg showing '3','2','1','4'; DIG0 seg=7'b0011001; dp stays 1.
3. Leading-zero blanking: load value_a=16'h0050 with blank_lz=1 ->
   - DIG2/DIG3 slots: an=4'b1111.
   - DIG1: seg=7'b0010010 ("5").
   - DIG0: seg=7'b1000000.
   - Then load 16'h0000 -> only DIG0 lit, showing "0".
4. Source B: sel_b=1, value_b=16'hBEEF, load -> DIG0 shows 'F' with dp=0, DIG1 shows 'E' (7'b0000110) with dp=1. Then load with sel_b=0 -> dp stays 1 on every digit.
5. Load/tick collision: load 16'h1111 then 16'h2222 exactly on a tick cycle -> that tick's digit shows '1'; the next slot shows '2'.
6. Mid-scan reset: resetn=0 for one clk while DIG2 is lit -> the next edge gives an=4'b1111, seg=7'b1111111, dp=1, shadow=0. After release the first tick lights DIG1 showing '0' (blank_lz=0).
